// File: rtl/axil_csr_sequencer.sv
// Table-driven AXI4-Lite master: runs a small command table of writes, reads and
// read-compares, pacing commands with an idle gap and bounding every handshake.
module axil_csr_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 256,
  parameter int GAP        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_we,
  input  logic [$clog2(DEPTH)-1:0] cmd_idx,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  input  logic [DATA_WIDTH-1:0]    cmd_mask,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [1:0]               err_code,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int IW   = $clog2(DEPTH);
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] PC_LAST  = IW'(DEPTH - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RDCMP = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam logic [1:0] EC_RESP = 2'b01;
  localparam logic [1:0] EC_CMP  = 2'b10;
  localparam logic [1:0] EC_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ADDR, S_RESP, S_GAP, S_DONE
  } state_e;

  // Command table: no reset, so a sequence survives rst and can be re-run.
  logic [1:0]            tbl_op   [DEPTH];
  logic [ADDR_WIDTH-1:0] tbl_addr [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_data [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_mask [DEPTH];

  state_e                state_q, state_d;
  logic [IW-1:0]         pc_q, pc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  error_q, error_d;
  logic [IW-1:0]         err_idx_q, err_idx_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;

  logic                  rec_err;
  logic [1:0]            rec_code;
  logic                  hs_done;
  logic                  adv;

  always_ff @(posedge clk) begin
    if (cmd_we && !busy) begin
      tbl_op[cmd_idx]   <= cmd_op;
      tbl_addr[cmd_idx] <= cmd_addr;
      tbl_data[cmd_idx] <= cmd_data;
      tbl_mask[cmd_idx] <= cmd_mask;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;
    rec_err    = 1'b0;
    rec_code   = 2'b00;
    hs_done    = 1'b0;
    adv        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          error_d    = 1'b0;
          err_idx_d  = '0;
          err_code_d = 2'b00;
        end
      end
      S_FETCH: begin
        op_d   = tbl_op[pc_q];
        addr_d = tbl_addr[pc_q];
        data_d = tbl_data[pc_q];
        mask_d = tbl_mask[pc_q];
        cnt_d  = '0;
        if (tbl_op[pc_q] == OP_END) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ADDR;
          if (tbl_op[pc_q] == OP_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + 1'b1;
        // AW and W retire independently; both must be gone before moving on.
        if (op_q == OP_WRITE) begin
          if (m_axi_awready) awvalid_d = 1'b0;
          if (m_axi_wready)  wvalid_d  = 1'b0;
          hs_done = !awvalid_d && !wvalid_d;
        end else begin
          if (m_axi_arready) arvalid_d = 1'b0;
          hs_done = !arvalid_d;
        end
        if (hs_done) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          rec_err   = 1'b1;
          rec_code  = EC_TMO;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          arvalid_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_WRITE) begin
          if (m_axi_bvalid) begin
            hs_done = 1'b1;
            if (m_axi_bresp != 2'b00) begin
              rec_err  = 1'b1;
              rec_code = EC_RESP;
            end
          end
        end else if (m_axi_rvalid) begin
          hs_done    = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = m_axi_rdata;
          rd_idx_d   = pc_q;
          if (m_axi_rresp != 2'b00) begin
            rec_err  = 1'b1;
            rec_code = EC_RESP;
          end else if (op_q == OP_RDCMP && ((m_axi_rdata ^ data_q) & mask_q) != '0) begin
            rec_err  = 1'b1;
            rec_code = EC_CMP;
          end
        end
        if (hs_done) begin
          if (rec_err) begin
            state_d = S_DONE;
          end else if (GAP == 0) begin
            adv = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end else if (cnt_q == TO_LAST) begin
          rec_err  = 1'b1;
          rec_code = EC_TMO;
          state_d  = S_DONE;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) adv = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The last slot completing acts as an implicit END.
    if (adv) begin
      if (pc_q == PC_LAST) begin
        state_d = S_DONE;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (rec_err) begin
      error_d = 1'b1;
      if (!error_q) begin
        err_idx_d  = pc_q;
        err_code_d = rec_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      op_q       <= 2'b00;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_ADDR) ||
                    (state_q == S_RESP)  || (state_q == S_GAP);
  assign done     = (state_q == S_DONE);
  assign error    = error_q;
  assign err_idx  = err_idx_q;
  assign err_code = err_code_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_idx   = rd_idx_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == S_RESP) && (op_q == OP_WRITE);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == S_RESP) && (op_q != OP_WRITE);

endmodule
